// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, SubBytes engine FSM encoding and the
// forward/inverse S-box tables with their lookup functions.
// No ports (package).
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entry 0 sits in the most significant byte, so entry x lives at index ~x.
  localparam logic [255:0][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[~x];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[~x];
  endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Combinational single-byte S-box lookup, forward or inverse.
// Ports: data_i - byte to substitute; inv_i - 1 selects the inverse S-box;
//        data_o - substituted byte.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = inv_i ? sbox_inv(data_i) : sbox_fwd(data_i);
  end

endmodule

// File: rtl/aes_subbytes_engine.sv
// Iterative AES SubBytes engine: substitutes the 16 bytes of a 128-bit state,
// LANES bytes per clock, lowest bytes first, with valid/ready on both sides.
// Ports: clk, rst (synchronous, active-low);
//        in_valid/in_ready/in_data/in_inv - block input, mode sampled at accept;
//        out_valid/out_ready/out_data     - substituted block, held until taken;
//        busy                             - high while a block is in flight.
module aes_subbytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int unsigned BEATS  = 16 / LANES;
  localparam int unsigned LANE_W = LANES * 8;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("aes_subbytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d;
  logic [AES_BLOCK_W-1:0] result_q, result_d;
  logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
  logic                   inv_q, inv_d;
  logic                   out_valid_q, busy_q, in_ready_q;

  // Block viewed as BEATS slices of LANES bytes; slice b is handled on beat b.
  logic [BEATS-1:0][LANE_W-1:0] work_beats;
  logic [BEATS-1:0][LANE_W-1:0] res_beats;
  logic [LANE_W-1:0]            lane_in;
  logic [LANE_W-1:0]            lane_out;

  assign work_beats = work_q;
  assign lane_in    = work_beats[beat_q];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lut u_lut (
      .data_i (lane_in[8*l +: 8]),
      .inv_i  (inv_q),
      .data_o (lane_out[8*l +: 8])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    work_d     = work_q;
    inv_d      = inv_q;
    result_d   = result_q;
    out_data_d = out_data_q;
    res_beats  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          work_d  = in_data;
          inv_d   = in_inv;
          beat_d  = '0;
        end
      end
      ST_BUSY: begin
        res_beats[beat_q] = lane_out;
        result_d          = res_beats;
        if (beat_q == LAST_BEAT) begin
          state_d    = ST_DONE;
          beat_d     = '0;
          out_data_d = res_beats;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      work_q      <= '0;
      result_q    <= '0;
      out_data_q  <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      work_q      <= work_d;
      result_q    <= result_d;
      out_data_q  <= out_data_d;
      inv_q       <= inv_d;
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_subbytes_engine.sv
// Self-checking bench for aes_subbytes_engine: one instance per legal LANES
// value, known-answer vectors, backpressure, mid-block reset, back-to-back
// throughput and randomized traffic against a GF(2^8)-derived S-box model.
module tb_aes_subbytes_engine;

  localparam int NCFG = 5;
  localparam int NBLK = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NCFG];
  logic         in_ready  [NCFG];
  logic [127:0] in_data   [NCFG];
  logic         in_inv    [NCFG];
  logic         out_valid [NCFG];
  logic         out_ready [NCFG];
  logic [127:0] out_data  [NCFG];
  logic         busy      [NCFG];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    aes_subbytes_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r, s, rot;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);  // x^254 = multiplicative inverse (0 -> 0)
    s = r; rot = r;
    for (int i = 0; i < 4; i++) begin
      rot = {rot[6:0], rot[7]};
      s = s ^ rot;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_block(input int k, input logic [127:0] d, input logic inv);
    int w;
    w = 0;
    while (!in_ready[k] && w < 100) begin tick(); w++; end
    in_valid[k] = 1'b1; in_data[k] = d; in_inv[k] = inv; out_ready[k] = 1'b0;
    tick();
    // scramble inputs after accept; the engine must ignore them
    in_valid[k] = 1'b0; in_data[k] = ~d; in_inv[k] = ~inv;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 100) begin tick(); lat++; end
  endtask

  task automatic handshake(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  typedef struct {
    int           k;
    logic [127:0] din;
    logic         inv;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [127:0] res, d, exp;
    logic [127:0] blk [12];
    int lat, idx, nout, cyc, last;
    logic acc, hs;

    for (int x = 0; x < 256; x++) begin
      fwd_t[x] = sbox_model(8'(x));
      inv_t[fwd_t[x]] = 8'(x);
    end

    vecs[0] = '{0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[1] = '{2, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{2, {16{8'hed}}, 1'b1, {16{8'h53}}};
    vecs[3] = '{2, {16{8'h52}}, 1'b0, {16{8'h00}}};
    vecs[4] = '{4, {16{8'h00}}, 1'b0, {16{8'h63}}};
    vecs[5] = '{3, {16{8'h63}}, 1'b1, {16{8'h00}}};
    vecs[6] = '{1, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b1, 128'h000102030405060708090a0b0c0d0e0f};

    rst = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0; out_ready[k] = 1'b0;
    end
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      check1("reset_in_ready", in_ready[k], 1'b1);
      check1("reset_out_valid", out_valid[k], 1'b0);
      check1("reset_busy", busy[k], 1'b0);
      check("reset_out_data", out_data[k], 128'h0);
    end
    tick();

    // known-answer vectors with latency
    for (int v = 0; v < 7; v++) begin
      start_block(vecs[v].k, vecs[v].din, vecs[v].inv);
      check1("kat_busy", busy[vecs[v].k], 1'b1);
      wait_valid(vecs[v].k, lat);
      res = out_data[vecs[v].k];
      check_int("kat_latency", lat, 16 / (1 << vecs[v].k));
      check("kat_data", res, vecs[v].dout);
      handshake(vecs[v].k);
      check1("kat_valid_drop", out_valid[vecs[v].k], 1'b0);
      check1("kat_in_ready_back", in_ready[vecs[v].k], 1'b1);
    end

    // backpressure on LANES=4
    d = {$urandom, $urandom, $urandom, $urandom};
    exp = model(d, 1'b0);
    start_block(2, d, 1'b0);
    wait_valid(2, lat);
    for (int c = 0; c < 10; c++) begin
      check1("bp_out_valid", out_valid[2], 1'b1);
      check("bp_out_data", out_data[2], exp);
      check1("bp_in_ready", in_ready[2], 1'b0);
      check1("bp_busy", busy[2], 1'b1);
      in_valid[2] = (c == 4); in_data[2] = ~d;
      tick();
    end
    in_valid[2] = 1'b0;
    handshake(2);
    check1("bp_release_valid", out_valid[2], 1'b0);
    check1("bp_release_in_ready", in_ready[2], 1'b1);
    check1("bp_release_busy", busy[2], 1'b0);
    tick();
    check1("bp_pulse_ignored", busy[2], 1'b0);

    // reset in the middle of a LANES=1 block
    d = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, d, 1'b0);
    repeat (7) tick();
    check1("mid_busy_before_reset", busy[0], 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check1("mid_reset_out_valid", out_valid[0], 1'b0);
    check1("mid_reset_busy", busy[0], 1'b0);
    check("mid_reset_out_data", out_data[0], 128'h0);
    check1("mid_reset_in_ready", in_ready[0], 1'b1);
    d = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, d, 1'b1);
    wait_valid(0, lat);
    check_int("post_reset_latency", lat, 16);
    check("post_reset_data", out_data[0], model(d, 1'b1));
    handshake(0);

    // back-to-back on LANES=16, modes alternating per block
    for (int i = 0; i < 12; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; nout = 0; cyc = 0; last = 0;
    out_ready[4] = 1'b1; in_valid[4] = 1'b1; in_data[4] = blk[0]; in_inv[4] = 1'b0;
    while (nout < 12 && cyc < 200) begin
      acc = in_valid[4] && in_ready[4];
      if (out_valid[4]) begin
        check("b2b_data", out_data[4], model(blk[nout], nout[0]));
        nout++;
      end
      tick(); cyc++;
      if (acc) begin
        if (idx > 0) check_int("b2b_interval", cyc - last, 3);
        last = cyc; idx++;
        if (idx < 12) begin
          in_data[4] = blk[idx]; in_inv[4] = idx[0];
        end else begin
          in_valid[4] = 1'b0;
        end
      end
    end
    check_int("b2b_count", nout, 12);
    in_valid[4] = 1'b0; out_ready[4] = 1'b0;
    tick();

    // randomized traffic, scoreboard per configuration
    for (int k = 0; k < NCFG; k++) begin
      logic [127:0] q [$];
      logic [127:0] held;
      logic hold;
      int sent, got, rc, lim;
      sent = 0; got = 0; rc = 0; hold = 1'b0; held = '0;
      lim = NBLK * (16 / (1 << k) + 2) * 4;
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      while (got < NBLK && rc < lim) begin
        if (in_ready[k]) begin
          if (sent < NBLK && $urandom_range(3) != 0) begin
            in_valid[k] = 1'b1;
            in_data[k] = {$urandom, $urandom, $urandom, $urandom};
            in_inv[k] = 1'($urandom_range(1));
          end else begin
            in_valid[k] = 1'b0;
          end
        end else begin
          in_valid[k] = 1'($urandom_range(1));
          in_data[k] = {$urandom, $urandom, $urandom, $urandom};
          in_inv[k] = 1'($urandom_range(1));
        end
        out_ready[k] = ($urandom_range(3) != 0);
        if (hold) begin
          check1("rnd_hold_valid", out_valid[k], 1'b1);
          check("rnd_hold_data", out_data[k], held);
        end
        acc = in_valid[k] && in_ready[k];
        hs = out_valid[k] && out_ready[k];
        hold = out_valid[k] && !out_ready[k];
        held = out_data[k];
        if (hs) begin
          check_int("rnd_output_expected", int'(q.size() > 0), 1);
          if (q.size() > 0) check("rnd_data", out_data[k], q.pop_front());
          got++;
        end
        if (acc) begin
          q.push_back(model(in_data[k], in_inv[k]));
          sent++;
        end
        tick(); rc++;
      end
      check_int("rnd_received", got, NBLK);
      check_int("rnd_sent", sent, NBLK);
      check_int("rnd_pending", q.size(), 0);
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
